// File: rtl/ctrl_bus_arbiter.sv
// ctrl_bus_arbiter
// ----------------------------------------------------------------------------
// Sole master of the shared pixel-write control bus that fans out to every
// ledpanel of the cube. Two pixel-write requesters are arbitrated round-robin
// with valid/ready handshakes. A fill engine can write one colour to every
// pixel of every panel (blanking, power-on clear). Writes aimed at panels
// that do not exist are handshaken, dropped and counted.
//
// Ports:
//   ctrl_clock   in   bus clock, the only clock
//   ctrl_reset   in   synchronous reset, active-high
//   reqN_valid   in   requester N has a write (N = 0, 1)
//   reqN_ready   out  requester N write accepted this cycle when valid&ready
//   reqN_panel   in   target panel index, 1-based
//   reqN_addr    in   pixel address
//   reqN_wdat    in   pixel datum (RGB888, red in bits 7:0)
//   fill_start   in   one-cycle pulse: start a fill
//   fill_color   in   fill colour, sampled with fill_start
//   fill_busy    out  fill engine active
//   fill_done    out  one-cycle pulse alongside the last fill write on the bus
//   ctrl_en      out  panel select, 0 = no write
//   ctrl_addr    out  write address
//   ctrl_wdat    out  write datum
//   drop_count   out  saturating count of dropped requests
// ----------------------------------------------------------------------------
module ctrl_bus_arbiter #(
   parameter int NUM_PANELS       = 6,
   parameter int PIXELS_PER_PANEL = 4096,
   parameter int ADDR_W           = 16,
   parameter int DATA_W           = 24
) (
   input  logic              ctrl_clock,
   input  logic              ctrl_reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [7:0]        req0_panel,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdat,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [7:0]        req1_panel,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdat,

   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_color,
   output logic              fill_busy,
   output logic              fill_done,

   output logic [7:0]        ctrl_en,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic [DATA_W-1:0] ctrl_wdat,
   output logic [15:0]       drop_count
);

   localparam logic [7:0]        LAST_PANEL = 8'(NUM_PANELS);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PIXELS_PER_PANEL - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Requester ports gathered into arrays so both are handled identically.
   // ------------------------------------------------------------------------
   logic [1:0]        req_valid;
   logic [7:0]        req_panel [2];
   logic [ADDR_W-1:0] req_addr  [2];
   logic [DATA_W-1:0] req_wdat  [2];
   logic [1:0]        panel_ok;
   logic [1:0]        grant;

   assign req_valid[0] = req0_valid;
   assign req_valid[1] = req1_valid;
   assign req_panel[0] = req0_panel;
   assign req_panel[1] = req1_panel;
   assign req_addr[0]  = req0_addr;
   assign req_addr[1]  = req1_addr;
   assign req_wdat[0]  = req0_wdat;
   assign req_wdat[1]  = req1_wdat;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t            state_reg;
   logic              last_grant_reg;
   logic [DATA_W-1:0] fill_color_reg;
   logic [7:0]        fill_panel_reg;
   logic [ADDR_W-1:0] fill_addr_reg;
   logic              fill_busy_reg;
   logic              fill_done_reg;
   logic [7:0]        ctrl_en_reg;
   logic [ADDR_W-1:0] ctrl_addr_reg;
   logic [DATA_W-1:0] ctrl_wdat_reg;
   logic [15:0]       drop_count_reg;

   // The requesters only get the bus while the fill engine is idle and not
   // being started; a starting fill takes priority over a pending request.
   logic arb_open;
   assign arb_open = (state_reg == ST_IDLE) && !fill_start;

   // Round-robin: with both valid, the one that did not win last time goes.
   // A lone valid requester always wins regardless of last_grant_reg.
   logic [1:0] other_valid;
   logic [1:0] turn;
   assign other_valid = {req_valid[0], req_valid[1]};
   assign turn        = {!last_grant_reg, last_grant_reg};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign panel_ok[gi] = (req_panel[gi] != 8'd0) && (req_panel[gi] <= LAST_PANEL);
         assign grant[gi]    = arb_open && req_valid[gi] && (!other_valid[gi] || turn[gi]);
      end
   endgenerate

   logic accept;
   logic sel;
   assign accept = |grant;
   assign sel    = grant[1];

   // ------------------------------------------------------------------------
   // Fill FSM, arbitration state and registered bus outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge ctrl_clock) begin
      if (ctrl_reset) begin
         state_reg      <= ST_IDLE;
         last_grant_reg <= 1'b1;
         fill_color_reg <= '0;
         fill_panel_reg <= '0;
         fill_addr_reg  <= '0;
         fill_busy_reg  <= 1'b0;
         fill_done_reg  <= 1'b0;
         ctrl_en_reg    <= '0;
         ctrl_addr_reg  <= '0;
         ctrl_wdat_reg  <= '0;
         drop_count_reg <= '0;
      end else begin
         // Default: nothing on the bus next cycle, no done pulse.
         ctrl_en_reg   <= 8'd0;
         fill_done_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (fill_start) begin
                  fill_color_reg <= fill_color;
                  fill_panel_reg <= 8'd1;
                  fill_addr_reg  <= '0;
                  fill_busy_reg  <= 1'b1;
                  state_reg      <= ST_FILL;
               end else if (accept) begin
                  last_grant_reg <= sel;
                  if (panel_ok[sel]) begin
                     ctrl_en_reg   <= req_panel[sel];
                     ctrl_addr_reg <= req_addr[sel];
                     ctrl_wdat_reg <= req_wdat[sel];
                  end else if (drop_count_reg != 16'hFFFF) begin
                     drop_count_reg <= drop_count_reg + 16'd1;
                  end
               end
            end

            ST_FILL: begin
               ctrl_en_reg   <= fill_panel_reg;
               ctrl_addr_reg <= fill_addr_reg;
               ctrl_wdat_reg <= fill_color_reg;
               if (fill_addr_reg == LAST_ADDR) begin
                  fill_addr_reg <= '0;
                  if (fill_panel_reg == LAST_PANEL) begin
                     // Last write issued: done pulse lines up with it on the bus.
                     state_reg     <= ST_DONE;
                     fill_busy_reg <= 1'b0;
                     fill_done_reg <= 1'b1;
                  end else begin
                     fill_panel_reg <= fill_panel_reg + 8'd1;
                  end
               end else begin
                  fill_addr_reg <= fill_addr_reg + ADDR_ONE;
               end
            end

            ST_DONE: begin
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign fill_busy  = fill_busy_reg;
   assign fill_done  = fill_done_reg;
   assign ctrl_en    = ctrl_en_reg;
   assign ctrl_addr  = ctrl_addr_reg;
   assign ctrl_wdat  = ctrl_wdat_reg;
   assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// tb_ctrl_bus_arbiter
// ----------------------------------------------------------------------------
// Directed bench for ctrl_bus_arbiter with a small geometry (2 panels of 16
// pixels) so a complete fill can be followed write by write.
// ----------------------------------------------------------------------------
module tb_ctrl_bus_arbiter;

   localparam int NP     = 2;
   localparam int PPP    = 16;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 24;

   logic              clk = 1'b0;
   logic              srst;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [7:0]        req0_panel, req1_panel;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic [DATA_W-1:0] req0_wdat, req1_wdat;
   logic              fill_start;
   logic [DATA_W-1:0] fill_color;
   logic              fill_busy, fill_done;
   logic [7:0]        ctrl_en;
   logic [ADDR_W-1:0] ctrl_addr;
   logic [DATA_W-1:0] ctrl_wdat;
   logic [15:0]       drop_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ctrl_bus_arbiter #(
      .NUM_PANELS      (NP),
      .PIXELS_PER_PANEL(PPP),
      .ADDR_W          (ADDR_W),
      .DATA_W          (DATA_W)
   ) dut (
      .ctrl_clock (clk),
      .ctrl_reset (srst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_panel (req0_panel),
      .req0_addr  (req0_addr),
      .req0_wdat  (req0_wdat),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_panel (req1_panel),
      .req1_addr  (req1_addr),
      .req1_wdat  (req1_wdat),
      .fill_start (fill_start),
      .fill_color (fill_color),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .ctrl_en    (ctrl_en),
      .ctrl_addr  (ctrl_addr),
      .ctrl_wdat  (ctrl_wdat),
      .drop_count (drop_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, obs);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      srst = 1'b1;
      tick();
      tick();
      srst = 1'b0;
   endtask

   initial begin
      int done_seen;
      int en_seen;

      srst       = 1'b1;
      req0_valid = 1'b0; req0_panel = '0; req0_addr = '0; req0_wdat = '0;
      req1_valid = 1'b0; req1_panel = '0; req1_addr = '0; req1_wdat = '0;
      fill_start = 1'b0; fill_color = '0;

      // ---------------- reset state ----------------
      tick();
      tick();
      srst = 1'b0;
      check("rst_ctrl_en",   32'(ctrl_en),    32'h0);
      check("rst_ctrl_addr", 32'(ctrl_addr),  32'h0);
      check("rst_ctrl_wdat", 32'(ctrl_wdat),  32'h0);
      check("rst_fill_busy", 32'(fill_busy),  32'h0);
      check("rst_fill_done", 32'(fill_done),  32'h0);
      check("rst_drop",      32'(drop_count), 32'h0);

      // ---------------- single write, 1-cycle latency ----------------
      req0_valid = 1'b1; req0_panel = 8'd2; req0_addr = 16'h0041; req0_wdat = 24'h00FF00;
      #1;
      check("w1_req0_ready", 32'(req0_ready), 32'h1);
      check("w1_req1_ready", 32'(req1_ready), 32'h0);
      tick();
      req0_valid = 1'b0;
      check("w1_en",   32'(ctrl_en),   32'h2);
      check("w1_addr", 32'(ctrl_addr), 32'h0041);
      check("w1_wdat", 32'(ctrl_wdat), 32'h00FF00);
      tick();
      check("w1_en_after", 32'(ctrl_en), 32'h0);

      // ---------------- round-robin, back-to-back ----------------
      apply_reset();
      req0_valid = 1'b1; req0_panel = 8'd1; req0_addr = 16'h0010; req0_wdat = 24'hAAAAAA;
      req1_valid = 1'b1; req1_panel = 8'd2; req1_addr = 16'h0020; req1_wdat = 24'hBBBBBB;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("rr%0d_ready0", i), 32'(req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
         check($sformatf("rr%0d_ready1", i), 32'(req1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
         tick();
         check($sformatf("rr%0d_en", i),   32'(ctrl_en),   (i % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("rr%0d_addr", i), 32'(ctrl_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      check("rr_idle_en", 32'(ctrl_en), 32'h0);

      // ---------------- invalid panels are dropped ----------------
      apply_reset();
      req1_valid = 1'b1; req1_addr = 16'h0003; req1_wdat = 24'h010203;
      req1_panel = 8'd0;
      #1;
      check("drop0_ready", 32'(req1_ready), 32'h1);
      tick();
      check("drop0_en",    32'(ctrl_en),    32'h0);
      check("drop0_count", 32'(drop_count), 32'h1);
      req1_panel = 8'(NP + 1);
      #1;
      check("drop3_ready", 32'(req1_ready), 32'h1);
      tick();
      check("drop3_en",    32'(ctrl_en),    32'h0);
      check("drop3_count", 32'(drop_count), 32'h2);
      req1_panel = 8'd7;
      tick();
      check("drop7_en",    32'(ctrl_en),    32'h0);
      check("drop7_count", 32'(drop_count), 32'h3);
      req1_panel = 8'(NP);
      tick();
      req1_valid = 1'b0;
      check("lastpanel_en",    32'(ctrl_en),    32'(NP));
      check("lastpanel_count", 32'(drop_count), 32'h3);

      // ---------------- full fill, colliding with req0 ----------------
      apply_reset();
      req0_valid = 1'b1; req0_panel = 8'd1; req0_addr = 16'h0005; req0_wdat = 24'h777777;
      fill_start = 1'b1; fill_color = 24'h123456;
      #1;
      check("fs_req0_ready", 32'(req0_ready), 32'h0);
      tick();
      fill_start = 1'b0; fill_color = 24'h000000;
      check("fs_busy", 32'(fill_busy), 32'h1);
      check("fs_en",   32'(ctrl_en),   32'h0);
      for (int k = 0; k < NP * PPP; k++) begin
         if (k == 5) begin
            fill_start = 1'b1;
            fill_color = 24'hFFFFFF;
         end else begin
            fill_start = 1'b0;
         end
         #1;
         check($sformatf("fill%0d_ready0", k), 32'(req0_ready), 32'h0);
         tick();
         check($sformatf("fill%0d_en", k),   32'(ctrl_en),   32'(k / PPP + 1));
         check($sformatf("fill%0d_addr", k), 32'(ctrl_addr), 32'(k % PPP));
         check($sformatf("fill%0d_wdat", k), 32'(ctrl_wdat), 32'h123456);
         check($sformatf("fill%0d_done", k), 32'(fill_done), (k == NP * PPP - 1) ? 32'h1 : 32'h0);
         check($sformatf("fill%0d_busy", k), 32'(fill_busy), (k == NP * PPP - 1) ? 32'h0 : 32'h1);
      end
      fill_start = 1'b0;
      // DONE cycle: requester still held off
      check("done_req0_ready", 32'(req0_ready), 32'h0);
      tick();
      check("post_done_pulse", 32'(fill_done), 32'h0);
      check("post_done_en",    32'(ctrl_en),   32'h0);
      check("post_req0_ready", 32'(req0_ready), 32'h1);
      tick();
      req0_valid = 1'b0;
      check("post_req0_en",   32'(ctrl_en),   32'h1);
      check("post_req0_addr", 32'(ctrl_addr), 32'h0005);
      check("post_req0_wdat", 32'(ctrl_wdat), 32'h777777);

      // ---------------- reset in the middle of a fill ----------------
      apply_reset();
      fill_start = 1'b1; fill_color = 24'h00AA55;
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
      end
      check("mid_before_en", 32'(ctrl_en), 32'h1);
      check("mid_before_addr", 32'(ctrl_addr), 32'h9);
      srst = 1'b1;   // asserted while write 10 would be issued
      tick();
      check("mid_rst_en",   32'(ctrl_en),   32'h0);
      check("mid_rst_busy", 32'(fill_busy), 32'h0);
      check("mid_rst_done", 32'(fill_done), 32'h0);
      srst = 1'b0;
      done_seen = 0;
      en_seen   = 0;
      for (int k = 0; k < 2 * NP * PPP; k++) begin
         tick();
         if (fill_done) done_seen++;
         if (ctrl_en != 8'd0) en_seen++;
      end
      check("mid_no_done",  32'(done_seen), 32'h0);
      check("mid_no_write", 32'(en_seen),   32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
